// File: rtl/matrix_mult_ctrl_if.sv
// Stream and multiplier-facing bus of matrix_mult_ctrl: row input, row output, and the A/B/C matrix buses.
interface matrix_mult_ctrl_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
) ();
    logic                       in_valid;
    logic                       in_ready;
    logic [N*WIDTH-1:0]         in_row;
    logic                       out_valid;
    logic                       out_ready;
    logic [N*2*WIDTH-1:0]       out_row;
    logic [N*N*WIDTH-1:0]       mm_a;
    logic [N*N*WIDTH-1:0]       mm_b;
    logic [N*N*2*WIDTH-1:0]     mm_c;

    modport slave (
        input  in_valid, in_row, out_ready, mm_c,
        output in_ready, out_valid, out_row, mm_a, mm_b
    );

    modport master (
        output in_valid, in_row, out_ready, mm_c,
        input  in_ready, out_valid, out_row, mm_a, mm_b
    );
endinterface

// File: rtl/matrix_mult_ctrl.sv
// Job sequencer for the matrix_mult datapath: load A and B rows, wait out the pipeline, drain C rows.
// Optional cycle counter output perf_cycles_o is enabled by defining MATRIX_MULT_CTRL_PERF_EN.
module matrix_mult_ctrl #(
    parameter int N           = 4,
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort_i,
    matrix_mult_ctrl_if.slave    bus,
    output logic                 busy_o,
    output logic                 done_o
`ifdef MATRIX_MULT_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_cycles_o
`endif
);
    localparam int RW     = N * WIDTH;
    localparam int CRW    = N * 2 * WIDTH;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int WAIT_W = $clog2(PIPE_STAGES + 2);

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        row_cnt_q;
    logic [CNT_W-1:0]        out_cnt_q;
    logic [WAIT_W-1:0]       wait_cnt_q;
    logic [N*N*WIDTH-1:0]    mm_a_q;
    logic [N*N*WIDTH-1:0]    mm_b_q;
    logic [N*N*2*WIDTH-1:0]  c_q;
    logic [CRW-1:0]          out_row_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic                    done_q;

    logic in_hs_s;
    logic out_hs_s;
    logic row_last_s;
    logic out_last_s;
    logic wait_end_s;

    assign in_hs_s    = bus.in_valid & in_ready_q;
    assign out_hs_s   = out_valid_q & bus.out_ready;
    assign row_last_s = (row_cnt_q == CNT_W'(N - 1));
    assign out_last_s = (out_cnt_q == CNT_W'(N - 1));
    assign wait_end_s = (wait_cnt_q == WAIT_W'(PIPE_STAGES));

    // Job sequencing FSM; every output is a register written here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD_A;
            row_cnt_q   <= '0;
            out_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
            c_q         <= '0;
            out_row_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort_i) begin
            // Operand and result storage survive an abort; only sequencing restarts.
            state_q     <= ST_LOAD_A;
            row_cnt_q   <= '0;
            out_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_LOAD_A: begin
                    in_ready_q <= 1'b1;
                    if (in_hs_s) begin
                        mm_a_q[32'(row_cnt_q) * RW +: RW] <= bus.in_row;
                        if (row_last_s) begin
                            row_cnt_q <= '0;
                            state_q   <= ST_LOAD_B;
                        end else begin
                            row_cnt_q <= row_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (in_hs_s) begin
                        mm_b_q[32'(row_cnt_q) * RW +: RW] <= bus.in_row;
                        if (row_last_s) begin
                            row_cnt_q  <= '0;
                            wait_cnt_q <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= ST_WAIT;
                        end else begin
                            row_cnt_q <= row_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_end_s) begin
                        // Row 0 is loaded from the same word being captured into c_q.
                        c_q         <= bus.mm_c;
                        out_row_q   <= bus.mm_c[0 +: CRW];
                        out_cnt_q   <= '0;
                        wait_cnt_q  <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DRAIN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_hs_s) begin
                        if (out_last_s) begin
                            out_cnt_q   <= '0;
                            row_cnt_q   <= '0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_LOAD_A;
                        end else begin
                            out_cnt_q <= out_cnt_q + CNT_W'(1);
                            out_row_q <= c_q[(32'(out_cnt_q) + 32'd1) * CRW +: CRW];
                        end
                    end
                end
                default: begin
                    state_q     <= ST_LOAD_A;
                    row_cnt_q   <= '0;
                    out_cnt_q   <= '0;
                    wait_cnt_q  <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.mm_a      = mm_a_q;
    assign bus.mm_b      = mm_b_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

`ifdef MATRIX_MULT_CTRL_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] perf_cnt_q;
    logic [31:0] perf_cycles_q;
    logic        perf_run_q;

    // Job cycle counter: while running, perf_cnt_q equals the 1-based index of the current cycle,
    // counting the first A-row handshake cycle as 1, so the done cycle is perf_cnt_q + 1 at the last handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q    <= 32'd0;
            perf_cycles_q <= 32'd0;
            perf_run_q    <= 1'b0;
        end else if (abort_i) begin
            perf_cnt_q <= 32'd0;
            perf_run_q <= 1'b0;
        end else if ((state_q == ST_LOAD_A) && in_hs_s && (row_cnt_q == CNT_W'(0))) begin
            perf_cnt_q <= 32'd2;
            perf_run_q <= 1'b1;
        end else if (perf_run_q) begin
            perf_cnt_q <= sat_inc(perf_cnt_q);
            if ((state_q == ST_DRAIN) && out_hs_s && out_last_s) begin
                perf_cycles_q <= sat_inc(perf_cnt_q);
                perf_run_q    <= 1'b0;
            end else begin
                perf_cycles_q <= perf_cycles_q;
            end
        end else begin
            perf_cnt_q <= perf_cnt_q;
        end
    end

    assign perf_cycles_o = perf_cycles_q;
`endif

endmodule

// File: doc/matrix_mult_ctrl.md
Name: matrix_mult_ctrl

Overview:
Sequencing controller for the matrix_mult datapath. It accepts operand matrices A and B as a stream of packed rows over a valid/ready handshake and holds them stable on the multiplier inputs. It waits out the multiplier pipeline latency, captures C, and streams C back out row by row with backpressure. One job runs at a time; this block owns the multiplier for the whole job.

Parameters:
N, 4, matrix dimension (rows = cols)
WIDTH, 16, operand element width; C elements are 2*WIDTH
PIPE_STAGES, 2, matrix_mult pipeline depth; sets the WAIT duration

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous job cancel
in_valid  in  1  input row valid
in_ready  out  1  input row accepted when in_valid && in_ready
in_row  in  N*WIDTH  packed row; element j at [j*WIDTH +: WIDTH]
mm_a  out  N*N*WIDTH  A to multiplier; A[r][j] at [(r*N+j)*WIDTH +: WIDTH]
mm_b  out  N*N*WIDTH  B to multiplier, same packing
mm_c  in  N*N*2*WIDTH  C from multiplier; C[r][j] at [(r*N+j)*2*WIDTH +: 2*WIDTH]
out_valid  out  1  output row valid
out_ready  in  1  output row consumed when out_valid && out_ready
out_row  out  N*2*WIDTH  packed C row; element j at [j*2*WIDTH +: 2*WIDTH]
busy  out  1  high in WAIT and DRAIN
done  out  1  one-cycle pulse on the final C row handshake

Behaviour:
- Reset (rst_n low, async): state=LOAD_A, row_cnt=0, wait_cnt=0, out_cnt=0, mm_a=0, mm_b=0, C capture register=0, out_valid=0, done=0, busy=0. in_ready=0 while rst_n is low; in_ready=1 from the first cycle after release.
- LOAD_A: in_ready=1. On each handshake, in_row is written to A row row_cnt and row_cnt increments. The handshake on row N-1 sets row_cnt=0 and moves to LOAD_B.
- LOAD_B: same as LOAD_A, but writes mm_b. The handshake on row N-1 moves to WAIT with wait_cnt=0.
- WAIT: in_ready=0, busy=1. wait_cnt increments each cycle. In the cycle where wait_cnt==PIPE_STAGES, mm_c is latched into the C register and the state moves to DRAIN with out_cnt=0. WAIT lasts exactly PIPE_STAGES+1 cycles.
- DRAIN: out_valid=1, out_row = C row out_cnt (registered, from the capture register only). out_row is held stable while out_ready=0. On a handshake, out_cnt increments. The handshake on row N-1 pulses done for one cycle, drops out_valid, and moves to LOAD_A with row_cnt=0.
- mm_a and mm_b change only on LOAD handshakes. They are stable through WAIT and DRAIN.
- in_valid outside LOAD_A/LOAD_B is ignored; no data is taken.
- abort (any state): on the next edge the state becomes LOAD_A. Counters clear, out_valid=0, done=0. mm_a, mm_b and the C register keep their contents. abort wins over a simultaneous in/out handshake, so that row is not counted and done does not fire.
- No inferred combinational path from in_valid to in_ready or from out_ready to out_valid.
- Asserting rst_n mid-job discards the job entirely. Reset values apply immediately.

Optional Feature:
MATRIX_MULT_CTRL_PERF_EN
- Defined:
  - Adds output perf_cycles, 32 bits, reset to 0.
  - An internal counter clears on the first A-row handshake of a job and increments every cycle until done.
  - On the done cycle, the final count (inclusive of both endpoints) is loaded into perf_cycles. It holds until the next done.
  - abort clears the internal counter; perf_cycles is left unchanged.
  - The counter saturates at 0xFFFFFFFF.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Stream A[i][j]=i+j and B=identity, with in_valid held high and out_ready=1 → out_row rows {0,1,2,3}, {1,2,3,4}, {2,3,4,5}, {3,4,5,6}. out_valid rises 3 cycles after the last B handshake; done is high for 1 cycle.
2. Same job with out_ready low for 5 cycles on row 1 → out_row stays {1,2,3,4} and out_valid stays 1. No row is skipped or repeated; done fires only after row 3.
3. Assert abort after 2 B rows are accepted → next cycle in_ready=1 in LOAD_A. A fresh full job with A=2*identity and B[i][j]=j yields rows {0,2,4,6} ×4.
4. in_valid pulsed high during WAIT and DRAIN → in_ready=0, mm_a and mm_b unchanged, result identical to scenario 1.
5. Drop rst_n in DRAIN at out_cnt=1 → out_valid=0, mm_a=0, busy=0 asynchronously. After release, in_ready=1 and a new job completes correctly.
6. With MATRIX_MULT_CTRL_PERF_EN defined, run scenario 1 with no stalls → perf_cycles=16 (8 load cycles + 3 wait + 4 drain + 1 boundary cycle); with 5 stall cycles → 21.
